// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and receiver state encoding
package uart_pkg;
  localparam int PRESCALE_W = 16;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for the idle-high serial line
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with valid/ready output and error pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_busy,
  output logic                  frame_error,
  output logic                  overrun_error
);
  rx_state_t state, state_n;
  logic rxs, tick, shift, good, bad;
  logic [PRESCALE_W-1:0] p, p_n, timer, timer_n, pin;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] sh;
  uart_sync u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxs));
  assign tick = timer == '0;
  assign pin = (prescale < 16'd2) ? 16'd2 : prescale;
  assign rx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    p_n = p;
    timer_n = tick ? timer : timer - 16'd1;
    bit_cnt_n = bit_cnt;
    shift = 1'b0;
    good = 1'b0;
    bad = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        p_n = pin;
        timer_n = (pin >> 1) - 16'd1;
      end
      START: if (tick) begin
        state_n = rxs ? IDLE : DATA;
        timer_n = rxs ? '0 : p - 16'd1;
        bit_cnt_n = '0;
      end
      DATA: if (tick) begin
        shift = 1'b1;
        timer_n = p - 16'd1;
        bit_cnt_n = bit_cnt + 4'd1;
        state_n = (bit_cnt == 4'(DATA_WIDTH - 1)) ? STOP : DATA;
      end
      STOP: if (tick) begin
        good = rxs;
        bad = !rxs;
        state_n = rxs ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: state_n = rxs ? IDLE : BREAK_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // shifting {rxs, sh} right keeps the first received bit ending up in bit 0, even for DATA_WIDTH=1
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      p <= 16'd2;
      timer <= '0;
      bit_cnt <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state <= state_n;
      p <= p_n;
      timer <= timer_n;
      bit_cnt <= bit_cnt_n;
      if (shift) sh <= DATA_WIDTH'({rxs, sh} >> 1);
      frame_error <= bad;
      overrun_error <= good && rx_valid && !rx_ready;
      if (good && (!rx_valid || rx_ready)) begin
        rx_data <= sh;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: serial driver loopback into uart_rx with a consumption scoreboard
module tb_uart_rx;
  logic clk = 0, rst = 1, rxd = 1, rx_ready = 0;
  logic [15:0] prescale = 16'd16;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_error, overrun_error;
  int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] sb[$];
  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_error(frame_error), .overrun_error(overrun_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  // every accepted word is compared against the oldest expected word
  always @(negedge clk)
    if (!rst) begin
      if (frame_error) fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) check("unexpected_word", sb.size(), 1);
        else check("sb_data", rx_data, sb.pop_front());
      end
    end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic uart_tx(input logic [7:0] d, input int p, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      idle(p);
    end
    rxd = 1;
  endtask
  task automatic consume;
    check("valid_before_take", rx_valid, 1);
    rx_ready = 1;
    idle(1);
    rx_ready = 0;
  endtask
  initial begin
    idle(3);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_flags", {frame_error, overrun_error}, 0);
    rst = 0;
    idle(3);
    sb.push_back(8'hA5);
    fork
      uart_tx(8'hA5, 16, 1);
      begin
        idle(154);
        check("t1_valid_pre", rx_valid, 0);
        idle(1);
        check("t1_valid_rise", rx_valid, 1);
        check("t1_data", rx_data, 8'hA5);
      end
    join
    idle(4);
    check("t1_flags", fe_cnt + ov_cnt, 0);
    consume;
    fork
      begin
        rxd = 0;
        idle(3);
        rxd = 1;
      end
      begin
        idle(10);
        check("t2_busy_mid", rx_busy, 1);
        idle(1);
        check("t2_busy_end", rx_busy, 0);
      end
    join
    idle(200);
    check("t2_valid", rx_valid, 0);
    check("t2_flags", fe_cnt + ov_cnt, 0);
    fork
      begin
        uart_tx(8'h3C, 16, 0);
        rxd = 0;
        idle(20);
        rxd = 1;
      end
      begin
        idle(156);
        check("t3_fe", fe_cnt, 1);
        check("t3_busy_hold", rx_busy, 1);
      end
    join
    idle(1);
    check("t3_busy_still", rx_busy, 1);
    idle(3);
    check("t3_busy_end", rx_busy, 0);
    check("t3_fe_single", fe_cnt, 1);
    check("t3_valid", rx_valid, 0);
    check("t3_ov", ov_cnt, 0);
    sb.push_back(8'h11);
    uart_tx(8'h11, 16, 1);
    idle(4);
    uart_tx(8'h22, 16, 1);
    idle(4);
    check("t4_ov", ov_cnt, 1);
    check("t4_hold", rx_data, 8'h11);
    check("t4_valid", rx_valid, 1);
    sb.push_back(8'h22);
    fork
      uart_tx(8'h22, 16, 1);
      begin
        idle(154);
        rx_ready = 1;
        idle(1);
        rx_ready = 0;
        check("t4_valid_kept", rx_valid, 1);
        check("t4_new", rx_data, 8'h22);
      end
    join
    idle(4);
    check("t4_no_ov", ov_cnt, 1);
    consume;
    fork
      uart_tx(8'hFF, 16, 1);
      begin
        idle(80);
        rst = 1;
        idle(2);
        rst = 0;
        check("t5_data", rx_data, 0);
        check("t5_valid", rx_valid, 0);
        check("t5_busy", rx_busy, 0);
        check("t5_flags", {frame_error, overrun_error}, 0);
      end
    join
    idle(4);
    check("t5_idle_busy", rx_busy, 0);
    check("t5_idle_valid", rx_valid, 0);
    sb.push_back(8'h5A);
    fork
      uart_tx(8'h5A, 16, 1);
      begin
        idle(40);
        prescale = 16'd3;
      end
    join
    idle(4);
    consume;
    prescale = 16'd1;
    sb.push_back(8'h81);
    uart_tx(8'h81, 2, 1);
    idle(4);
    check("t6_data", rx_data, 8'h81);
    consume;
    idle(4);
    check("end_fe", fe_cnt, 1);
    check("end_ov", ov_cnt, 1);
    check("end_sb", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
